// File: rtl/regbank_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// regbank_rmw_ctrl
// Command-driven read-modify-write initiator for a small register bank.
// It accepts one command per cmd handshake. It reads two bank registers,
// computes ADD/SUB/AND/LDI, writes the result back for one cycle, and then
// presents the result on the response channel.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both 1. Valid may not depend on ready. The payload is held stable while
// valid is high and ready is low.
//
// Ports
//   clk, rst_n             clock (shared with the bank), async active-low reset
//   cmd_valid/cmd_ready    command handshake
//   cmd_op                 00 ADD, 01 SUB, 10 AND, 11 LDI
//   cmd_src1/src2/dst      operand and destination register addresses
//   cmd_imm                immediate for LDI
//   rsp_valid/rsp_ready    response handshake
//   rsp_data/carry/zero    written value, carry (ADD) / borrow (SUB), zero flag
//   rb_ra1/rb_ra2          bank read addresses
//   rb_rdata1/rb_rdata2    bank read data, combinational from the read addresses
//   rb_wa/rb_write/rb_wdata bank write port
//   dbg_state              current FSM state, for observation only
// -----------------------------------------------------------------------------
module regbank_rmw_ctrl #(
   parameter int DW = 32,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [AW-1:0] cmd_src1,
   input  logic [AW-1:0] cmd_src2,
   input  logic [AW-1:0] cmd_dst,
   input  logic [DW-1:0] cmd_imm,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_carry,
   output logic          rsp_zero,
   output logic [AW-1:0] rb_ra1,
   output logic [AW-1:0] rb_ra2,
   output logic [AW-1:0] rb_wa,
   output logic          rb_write,
   output logic [DW-1:0] rb_wdata,
   input  logic [DW-1:0] rb_rdata1,
   input  logic [DW-1:0] rb_rdata2,
   output logic [2:0]    dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_EXEC  = 3'd2,
      S_WRITE = 3'd3,
      S_RESP  = 3'd4
   } state_e;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_LDI = 2'b11;

   state_e        state_q, state_d;
   logic [1:0]    op_q, op_d;
   logic [AW-1:0] src1_q, src1_d;
   logic [AW-1:0] src2_q, src2_d;
   logic [AW-1:0] dst_q, dst_d;
   logic [DW-1:0] imm_q, imm_d;
   logic [DW-1:0] op1_q, op1_d;
   logic [DW-1:0] op2_q, op2_d;
   logic [DW-1:0] result_q, result_d;
   logic          carry_q, carry_d;
   logic          zero_q, zero_d;

   // The extra top bit carries the ADD carry-out. For SUB it is the borrow,
   // which is set exactly when op1 < op2 (unsigned).
   logic [DW:0]   alu;

   always_comb begin
      alu = '0;
      case (op_q)
         OP_ADD:  alu = {1'b0, op1_q} + {1'b0, op2_q};
         OP_SUB:  alu = {1'b0, op1_q} - {1'b0, op2_q};
         OP_AND:  alu = {1'b0, op1_q & op2_q};
         OP_LDI:  alu = {1'b0, imm_q};
         default: alu = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      src1_d   = src1_q;
      src2_d   = src2_q;
      dst_d    = dst_q;
      imm_d    = imm_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      result_d = result_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d    = cmd_op;
               src1_d  = cmd_src1;
               src2_d  = cmd_src2;
               dst_d   = cmd_dst;
               imm_d   = cmd_imm;
               state_d = S_READ;
            end
         end
         S_READ: begin
            // The read addresses have been stable all cycle, so the bank's
            // combinational data is settled by the closing edge.
            op1_d   = rb_rdata1;
            op2_d   = rb_rdata2;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            result_d = alu[DW-1:0];
            carry_d  = alu[DW];
            zero_d   = (alu[DW-1:0] == '0);
            state_d  = S_WRITE;
         end
         S_WRITE: begin
            state_d = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         src1_q   <= '0;
         src2_q   <= '0;
         dst_q    <= '0;
         imm_q    <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         src1_q   <= src1_d;
         src2_q   <= src2_d;
         dst_q    <= dst_d;
         imm_q    <= imm_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
      end
   end

   // The control strobes decode straight from the state register. A reset
   // forces IDLE asynchronously, so rb_write falls at once and no bank write
   // can happen at the next edge.
   assign cmd_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rb_write  = (state_q == S_WRITE);

   assign rb_ra1    = src1_q;
   assign rb_ra2    = src2_q;
   assign rb_wa     = dst_q;
   assign rb_wdata  = result_q;
   assign rsp_data  = result_q;
   assign rsp_carry = carry_q;
   assign rsp_zero  = zero_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_regbank_rmw_ctrl.sv
module tb_regbank_rmw_ctrl;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [1:0]  cmd_src1, cmd_src2, cmd_dst;
   logic [31:0] cmd_imm;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_carry;
   logic        rsp_zero;
   logic [1:0]  rb_ra1, rb_ra2, rb_wa;
   logic        rb_write;
   logic [31:0] rb_wdata;
   logic [31:0] rb_rdata1, rb_rdata2;
   logic [2:0]  dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- register bank model ----------------
   logic [31:0] bank [4] = '{default: 32'h0};
   int          wr_cnt = 0;
   int          cyc    = 0;

   assign rb_rdata1 = bank[rb_ra1];
   assign rb_rdata2 = bank[rb_ra2];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rb_write) begin
         bank[rb_wa] <= rb_wdata;
         wr_cnt      <= wr_cnt + 1;
      end
   end

   regbank_rmw_ctrl #(.DW(32), .AW(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_src1  (cmd_src1),
      .cmd_src2  (cmd_src2),
      .cmd_dst   (cmd_dst),
      .cmd_imm   (cmd_imm),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_carry (rsp_carry),
      .rsp_zero  (rsp_zero),
      .rb_ra1    (rb_ra1),
      .rb_ra2    (rb_ra2),
      .rb_wa     (rb_wa),
      .rb_write  (rb_write),
      .rb_wdata  (rb_wdata),
      .rb_rdata1 (rb_rdata1),
      .rb_rdata2 (rb_rdata2),
      .dbg_state (dbg_state)
   );

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   // Issue one command from IDLE and return at the first negedge where
   // rsp_valid is seen. lat counts the negedges after the accept edge.
   task automatic do_cmd(input logic [1:0] op, input logic [1:0] s1, input logic [1:0] s2,
                         input logic [1:0] d, input logic [31:0] imm,
                         output logic [31:0] data, output logic c, output logic z,
                         output int lat);
      @(negedge clk);
      cmd_op    = op;
      cmd_src1  = s1;
      cmd_src2  = s2;
      cmd_dst   = d;
      cmd_imm   = imm;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      data = rsp_data;
      c    = rsp_carry;
      z    = rsp_zero;
   endtask

   task automatic run_check(input string tag, input logic [1:0] op, input logic [1:0] s1,
                            input logic [1:0] s2, input logic [1:0] d, input logic [31:0] imm,
                            input logic [31:0] exp_data, input logic exp_c, input logic exp_z);
      logic [31:0] data;
      logic        c, z;
      int          lat;
      do_cmd(op, s1, s2, d, imm, data, c, z, lat);
      check({tag, "_lat"},   lat,  4);
      check({tag, "_data"},  data, exp_data);
      check({tag, "_carry"}, c,    exp_c);
      check({tag, "_zero"},  z,    exp_z);
   endtask

   localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, AND = 2'b10, LDI = 2'b11;

   // ---------------- stimulus ----------------
   initial begin
      int          w0, ok, k, lat;
      int          acc [3];
      logic [1:0]  t_op [3];
      logic [1:0]  t_s1 [3];
      logic [1:0]  t_s2 [3];
      logic [1:0]  t_d  [3];
      logic [31:0] t_exp [3];
      logic        t_c  [3];

      rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
      cmd_op = 2'b00; cmd_src1 = 2'd0; cmd_src2 = 2'd0; cmd_dst = 2'd0; cmd_imm = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rb_write",  rb_write,  0);
      check("rst_rsp_data",  rsp_data,  0);
      check("rst_rsp_flags", {rsp_carry, rsp_zero}, 0);
      check("rst_addr",      {rb_ra1, rb_ra2, rb_wa}, 0);
      check("rst_wdata",     rb_wdata, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1);

      // 1: reset asserted during WRITE suppresses the bank write
      w0 = wr_cnt;
      cmd_op = LDI; cmd_src1 = 2'd0; cmd_src2 = 2'd0; cmd_dst = 2'd1; cmd_imm = 32'h0000_DEAD;
      cmd_valid = 1'b1;
      @(negedge clk);            // READ
      cmd_valid = 1'b0;
      @(negedge clk);            // EXEC
      @(negedge clk);            // WRITE
      check("t1_in_write", rb_write, 1);
      rst_n = 1'b0;
      #1;
      check("t1_write_drop", rb_write, 0);
      check("t1_rsp_valid",  rsp_valid, 0);
      @(negedge clk);
      check("t1_bank_r1", bank[1], 32'h0);
      check("t1_no_write", wr_cnt - w0, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("t1_cmd_ready", cmd_ready, 1);
      check("t1_rsp_data",  rsp_data, 0);

      // 2: LDI/LDI/ADD with carry
      run_check("t2_ldi_r1", LDI, 2'd0, 2'd0, 2'd1, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0);
      run_check("t2_ldi_r2", LDI, 2'd0, 2'd0, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_check("t2_add",    ADD, 2'd1, 2'd2, 2'd3, 32'h0,         32'h0000_0004, 1'b1, 1'b0);
      @(negedge clk);
      check("t2_bank_r3", bank[3], 32'h0000_0004);

      // 3: SUB to zero, SUB with borrow
      run_check("t3_sub_zero",   SUB, 2'd1, 2'd1, 2'd0, 32'h0, 32'h0000_0000, 1'b0, 1'b1);
      run_check("t3_sub_borrow", SUB, 2'd1, 2'd2, 2'd0, 32'h0, 32'h0000_0006, 1'b1, 1'b0);

      // 4: AND with src == dst, then read the updated register back
      run_check("t4_ldi_r1", LDI, 2'd0, 2'd0, 2'd1, 32'hF0F0_00FF, 32'hF0F0_00FF, 1'b0, 1'b0);
      run_check("t4_ldi_r2", LDI, 2'd0, 2'd0, 2'd2, 32'h0FF0_FF0F, 32'h0FF0_FF0F, 1'b0, 1'b0);
      run_check("t4_and",    AND, 2'd1, 2'd2, 2'd1, 32'h0,         32'h00F0_000F, 1'b0, 1'b0);
      run_check("t4_reread", AND, 2'd1, 2'd1, 2'd3, 32'h0,         32'h00F0_000F, 1'b0, 1'b0);

      // 5: response backpressure
      @(negedge clk);
      rsp_ready = 1'b0;
      w0 = wr_cnt;
      run_check("t5_ldi", LDI, 2'd0, 2'd0, 2'd2, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
      ok = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_data !== 32'h1234_5678 || cmd_ready !== 1'b0) ok = 0;
      end
      check("t5_stable", ok, 1);
      check("t5_one_write", wr_cnt - w0, 1);
      rsp_ready = 1'b1;
      @(negedge clk);
      check("t5_release", {rsp_valid, cmd_ready}, 2'b01);

      // 6: back-to-back commands, rsp_ready held high
      t_op[0] = ADD; t_s1[0] = 2'd1; t_s2[0] = 2'd2; t_d[0] = 2'd0; t_exp[0] = 32'h1324_5687; t_c[0] = 1'b0;
      t_op[1] = SUB; t_s1[1] = 2'd2; t_s2[1] = 2'd0; t_d[1] = 2'd3; t_exp[1] = 32'hFF0F_FFF1; t_c[1] = 1'b1;
      t_op[2] = ADD; t_s1[2] = 2'd0; t_s2[2] = 2'd0; t_d[2] = 2'd1; t_exp[2] = 32'h2648_AD0E; t_c[2] = 1'b0;
      w0 = wr_cnt;
      cmd_op = t_op[0]; cmd_src1 = t_s1[0]; cmd_src2 = t_s2[0]; cmd_dst = t_d[0]; cmd_imm = 32'h0;
      cmd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         k = 0;
         while (!cmd_ready && k < 20) begin
            @(negedge clk);
            k++;
         end
         acc[i] = cyc;
         @(negedge clk);         // accepted; READ
         if (i < 2) begin
            cmd_op = t_op[i+1]; cmd_src1 = t_s1[i+1]; cmd_src2 = t_s2[i+1]; cmd_dst = t_d[i+1];
         end else begin
            cmd_valid = 1'b0;
         end
         lat = 1;
         while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         check($sformatf("t6_lat%0d", i),   lat, 4);
         check($sformatf("t6_data%0d", i),  rsp_data, t_exp[i]);
         check($sformatf("t6_carry%0d", i), rsp_carry, t_c[i]);
         @(negedge clk);
      end
      check("t6_interval01", acc[1] - acc[0], 5);
      check("t6_interval12", acc[2] - acc[1], 5);
      check("t6_writes", wr_cnt - w0, 3);
      check("t6_bank_r1", bank[1], 32'h2648_AD0E);
      check("t6_bank_r3", bank[3], 32'hFF0F_FFF1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
